// File: rtl/spi_pkg.sv
// Shared constants, register map and FSM state type for the SPI write controller.
package spi_pkg;

    localparam int unsigned FRAME_BITS = 16;
    localparam logic        WRITE_BIT  = 1'b1;

    localparam logic [6:0] REG_EN_OUT_7_0  = 7'h00;
    localparam logic [6:0] REG_EN_OUT_15_8 = 7'h01;
    localparam logic [6:0] REG_EN_PWM_7_0  = 7'h02;
    localparam logic [6:0] REG_EN_PWM_15_8 = 7'h03;
    localparam logic [6:0] REG_PWM_DUTY    = 7'h04;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT,
        ST_HOLD,
        ST_GAP
    } spi_state_t;

    function automatic logic [FRAME_BITS-1:0] build_frame(input logic [6:0] addr,
                                                          input logic [7:0] wdata);
        return {WRITE_BIT, addr, wdata};
    endfunction

endpackage

// File: rtl/spi_tick_gen.sv
// Half-period tick generator: one-cycle tick every HALF_DIV clocks while enabled.
module spi_tick_gen #(
    parameter int unsigned HALF_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);

    localparam logic [7:0] WRAP = 8'(HALF_DIV - 1);

    logic [7:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (!en || cnt == WRAP) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 8'd1;
        end
    end

    assign tick = en && (cnt == WRAP);

endmodule

// File: rtl/spi_controller.sv
// SPI mode-0 write-only master: sends {1, addr[6:0], wdata[7:0]} MSB first per start request.
module spi_controller
    import spi_pkg::*;
#(
    parameter int unsigned HALF_DIV = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [6:0] addr,
    input  logic [7:0] wdata,
    output logic       sclk,
    output logic       copi,
    output logic       ncs,
    output logic       busy,
    output logic       done
);

    localparam logic [4:0] LAST_BIT = 5'(FRAME_BITS);

    spi_state_t            state, state_nxt;
    logic [FRAME_BITS-1:0] shreg;
    logic [4:0]            bit_cnt;
    logic                  gap_half;
    logic                  tick, tick_en;
    logic                  load, rise, fall, finish;

    assign tick_en = (state != ST_IDLE);

    spi_tick_gen #(.HALF_DIV(HALF_DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .en   (tick_en),
        .tick (tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // The rise ending SETUP is the first sclk edge; SHIFT then runs 32 half-periods,
    // the last one low after the 16th falling edge, before HOLD.
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        rise      = 1'b0;
        fall      = 1'b0;
        finish    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    load      = 1'b1;
                    state_nxt = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (tick) begin
                    rise      = 1'b1;
                    state_nxt = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (tick) begin
                    if (sclk) begin
                        fall = 1'b1;
                    end else if (bit_cnt == LAST_BIT) begin
                        state_nxt = ST_HOLD;
                    end else begin
                        rise = 1'b1;
                    end
                end
            end
            ST_HOLD: begin
                if (tick) begin
                    finish    = 1'b1;
                    state_nxt = ST_GAP;
                end
            end
            ST_GAP: begin
                if (tick && gap_half) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg    <= '0;
            bit_cnt  <= '0;
            sclk     <= 1'b0;
            gap_half <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= finish;
            if (load) begin
                shreg    <= build_frame(addr, wdata);
                bit_cnt  <= '0;
                gap_half <= 1'b0;
            end
            if (rise) begin
                sclk <= 1'b1;
                if (bit_cnt != LAST_BIT) begin
                    bit_cnt <= bit_cnt + 5'd1;
                end
            end
            if (fall) begin
                sclk  <= 1'b0;
                shreg <= {shreg[FRAME_BITS-2:0], 1'b0};
            end
            if (state == ST_GAP && tick) begin
                gap_half <= ~gap_half;
            end
        end
    end

    assign ncs  = !(state inside {ST_SETUP, ST_SHIFT, ST_HOLD});
    assign copi = !ncs && shreg[FRAME_BITS-1];
    assign busy = (state != ST_IDLE);

endmodule
